// File: rtl/sp_ram_pkg.sv
// Shared constants and helpers for the single-port RAM arbiter and its grant logic.
package sp_ram_pkg;

  localparam logic RDWEN_WRITE = 1'b1;
  localparam logic RDWEN_READ  = 1'b0;

  // Index width for a requester id; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority round-robin grant with a registered last-granted pointer.
module rr_arbiter
  import sp_ram_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     gnt_id_o,
  output logic               gnt_vld_o
);

  logic [IDW-1:0]     last_q, last_d;
  logic [IDW-1:0]     idx;
  logic [NUM_REQ-1:0] req_g;

  // Requests are masked while reset is held so nothing is granted during reset.
  assign req_g = req_i & {NUM_REQ{rst_ni}};

  always_comb begin
    gnt_o     = '0;
    gnt_id_o  = '0;
    gnt_vld_o = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(last_q) + k) % NUM_REQ);
      if (!gnt_vld_o && req_g[idx]) begin
        gnt_vld_o  = 1'b1;
        gnt_id_o   = idx;
        gnt_o[idx] = 1'b1;
      end
    end
  end

  assign last_d = gnt_vld_o ? gnt_id_o : last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= IDW'(NUM_REQ - 1);
    else         last_q <= last_d;
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port RAM between NUM_REQ requesters; reads answer one cycle after grant.
module sp_ram_arbiter
  import sp_ram_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_bw_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic [ADDR_WIDTH-1:0]         ram_a_o,
  output logic [DATA_WIDTH-1:0]         ram_di_o,
  output logic [DATA_WIDTH-1:0]         ram_bw_o,
  output logic                          ram_ce_o,
  output logic                          ram_rdwen_o,
  input  logic [DATA_WIDTH-1:0]         ram_do_i
);

  localparam int IDW = clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic               gnt_vld;
  logic               we_sel;

  logic               pend_v_q, pend_v_d;
  logic [IDW-1:0]     pend_id_q, pend_id_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_valid_i),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id),
    .gnt_vld_o (gnt_vld)
  );

  assign req_ready_o = gnt;
  assign ram_ce_o    = gnt_vld;

  // One-hot AND-OR mux; all RAM fields stay zero when nobody is granted.
  always_comb begin
    ram_a_o  = '0;
    ram_di_o = '0;
    ram_bw_o = '0;
    we_sel   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        ram_a_o  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_di_o = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        ram_bw_o = req_bw_i[i*DATA_WIDTH +: DATA_WIDTH];
        we_sel   = req_we_i[i];
      end
    end
  end

  assign ram_rdwen_o = we_sel ? RDWEN_WRITE : RDWEN_READ;

  assign pend_v_d  = gnt_vld && !we_sel;
  assign pend_id_d = pend_v_d ? gnt_id : pend_id_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_v_q  <= 1'b0;
      pend_id_q <= '0;
    end else begin
      pend_v_q  <= pend_v_d;
      pend_id_q <= pend_id_d;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_valid_o[i] = pend_v_q && (pend_id_q == IDW'(i));
  end

  // RAM output is already registered, so read data passes straight through.
  assign rsp_data_o = ram_do_i;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Randomized + directed bench for sp_ram_arbiter against a queue/array reference model.
module tb_sp_ram_arbiter;

  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_we = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N*DW-1:0]   req_bw = '0;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic [AW-1:0]     ram_a;
  logic [DW-1:0]     ram_di;
  logic [DW-1:0]     ram_bw;
  logic              ram_ce;
  logic              ram_rdwen;
  logic [DW-1:0]     ram_do;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sp_ram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_bw_i    (req_bw),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .ram_a_o     (ram_a),
    .ram_di_o    (ram_di),
    .ram_bw_o    (ram_bw),
    .ram_ce_o    (ram_ce),
    .ram_rdwen_o (ram_rdwen),
    .ram_do_i    (ram_do)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 37 + 11);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Environment: single-port RAM with registered read data and bit-masked writes.
  logic [DW-1:0] ram_mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_val(i);
    ram_do <= '0;
    forever begin
      @(posedge clk);
      if (ram_ce) begin
        if (ram_rdwen) ram_mem[ram_a] <= (ram_mem[ram_a] & ~ram_bw) | (ram_di & ram_bw);
        else           ram_do <= ram_mem[ram_a];
      end
    end
  end

  // Reference model + per-cycle compare, sampled on the falling edge.
  logic [DW-1:0] ref_mem [DEPTH];
  initial begin
    int m_last, m_pid, g, idx;
    bit m_pv, we;
    logic [DW-1:0] m_pdata, wd, bw;
    logic [AW-1:0] a;
    logic [N-1:0] exp_rsp, exp_rdy;
    int waits [N];
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    m_last = N - 1; m_pv = 0; m_pid = 0; m_pdata = '0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_ready", req_ready, 0);
        chk("rst_ce", ram_ce, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        m_last = N - 1; m_pv = 0;
        for (int i = 0; i < N; i++) waits[i] = 0;
      end else begin
        exp_rsp = '0;
        if (m_pv) exp_rsp[m_pid] = 1'b1;
        chk("rsp_valid", rsp_valid, exp_rsp);
        if (m_pv) chk("rsp_data", rsp_data, m_pdata);
        g = -1;
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (g < 0 && req_valid[idx]) g = idx;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        chk("ram_ce", ram_ce, (g >= 0) ? 1 : 0);
        if (g >= 0) begin
          a  = req_addr[g*AW +: AW];
          wd = req_wdata[g*DW +: DW];
          bw = req_bw[g*DW +: DW];
          we = req_we[g];
          chk("ram_a", ram_a, a);
          chk("ram_rdwen", ram_rdwen, we);
          if (we) begin
            chk("ram_di", ram_di, wd);
            chk("ram_bw", ram_bw, bw);
            ref_mem[a] = (ref_mem[a] & ~bw) | (wd & bw);
            m_pv = 0;
          end else begin
            m_pv = 1; m_pid = g; m_pdata = ref_mem[a];
          end
          m_last = g;
        end else begin
          chk("idle_ram_a", ram_a, 0);
          chk("idle_ram_di", ram_di, 0);
          chk("idle_ram_bw", ram_bw, 0);
          m_pv = 0;
        end
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && !req_ready[i]) begin
            waits[i]++;
            chk("fair_wait_bound", (waits[i] <= N - 1) ? 1 : 0, 1);
          end else begin
            waits[i] = 0;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input bit we, input int addr,
                         input int wd, input int bw);
    req_valid[i] = v;
    req_we[i] = we;
    req_addr[i*AW +: AW] = AW'(addr);
    req_wdata[i*DW +: DW] = DW'(wd);
    req_bw[i*DW +: DW] = DW'(bw);
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [N-1:0] rdy;
    // Reset with every requester asking
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, 0, 0);
    cyc(); cyc(); #2;
    chk("lit_rst_ready", req_ready, 0);
    chk("lit_rst_ce", ram_ce, 0);
    chk("lit_rst_rsp", rsp_valid, 0);
    cyc(); rst_n = 1'b1; #2;
    chk("lit_first_gnt", req_ready, 3'b001);

    // Single requester write then read back
    cyc(); idle_all(); set_req(1, 1, 1, 3, 8'hA5, 8'hFF); #2;
    chk("lit_wr1_ready", req_ready, 3'b010);
    cyc(); set_req(1, 1, 0, 3, 0, 0); #2;
    chk("lit_rd1_ready", req_ready, 3'b010);
    cyc(); idle_all(); #2;
    chk("lit_rd1_rsp_valid", rsp_valid, 3'b010);
    chk("lit_rd1_rsp_data", rsp_data, 8'hA5);

    // Bit-masked write
    cyc(); set_req(0, 1, 1, 5, 8'hFF, 8'hFF); #2;
    chk("lit_mask_ready", req_ready, 3'b001);
    cyc(); set_req(0, 1, 1, 5, 8'h00, 8'h0F);
    cyc(); set_req(0, 1, 0, 5, 0, 0);
    cyc(); idle_all(); #2;
    chk("lit_mask_rsp_valid", rsp_valid, 3'b001);
    chk("lit_mask_rsp_data", rsp_data, 8'hF0);

    // Three-way contention after a fresh reset
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 8 + i, 0, 0);
    for (int k = 0; k < 9; k++) begin
      #2;
      chk("lit_rr_order", req_ready, 3'b001 << (k % 3));
      cyc();
    end

    // Held request: req1 waits one cycle, address taken on its grant
    idle_all(); set_req(0, 1, 0, 1, 0, 0); set_req(1, 1, 0, 7, 0, 0); #2;
    chk("lit_hold_first", req_ready, 3'b001);
    cyc(); set_req(0, 0, 0, 0, 0, 0); #2;
    chk("lit_hold_second", req_ready, 3'b010);
    chk("lit_hold_addr", ram_a, 7);

    // Reset while a read is outstanding
    cyc(); idle_all(); set_req(2, 1, 0, 2, 0, 0); #2;
    chk("lit_mid_rd_ready", req_ready, 3'b100);
    cyc(); idle_all(); rst_n = 1'b0; #2;
    chk("lit_mid_rst_rsp", rsp_valid, 0);
    cyc(); rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1, 1, i, 8'h3C, 8'hFF);
    #2;
    chk("lit_post_rst_gnt", req_ready, 3'b001);
    cyc(); idle_all(); #2;
    chk("lit_post_rst_rsp", rsp_valid, 0);

    // Random traffic obeying the hold-until-ready rule, with rare resets
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rdy = req_ready;
      cyc();
      rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !rdy[i]))
          set_req(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  $urandom_range(0, DEPTH - 1), $urandom, $urandom);
      end
    end

    cyc(); idle_all(); rst_n = 1'b1;
    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Round-robin arbiter that shares one single-port RAM instance (`sp_ram_model` pin interface: A, DI, BW, CE, RDWEN, DO) between NUM_REQ independent requesters. Each requester issues read or bit-masked write requests over a valid/ready handshake; at most one access reaches the RAM per cycle. Read data is returned one cycle later with a per-requester response strobe. It sits between cache/tag controllers and the RAM macro or BRAM model.

## Interface
- NUM_REQ, 2: number of requesters (≥2).
- ADDR_WIDTH, 1: RAM address width.
- DATA_WIDTH, 1: RAM data and bit-write-mask width.
- CLK  in  1  clock; all state on posedge.
- RST_N  in  1  reset; one clock, asynchronous assert, active-low.
- REQ_VALID  in  NUM_REQ  request valid per requester.
- REQ_READY  out  NUM_REQ  request accepted this cycle (one-hot or zero).
- REQ_WE  in  NUM_REQ  1 = write, 0 = read.
- REQ_ADDR  in  NUM_REQ*ADDR_WIDTH  address; requester i at slice i.
- REQ_WDATA  in  NUM_REQ*DATA_WIDTH  write data.
- REQ_BW  in  NUM_REQ*DATA_WIDTH  per-bit write enable.
- RSP_VALID  out  NUM_REQ  one-cycle read-data strobe, one-hot or zero.
- RSP_DATA  out  DATA_WIDTH  read data, shared by all requesters, qualified by RSP_VALID.
- RAM_A  out  ADDR_WIDTH  to RAM A.
- RAM_DI  out  DATA_WIDTH  to RAM DI.
- RAM_BW  out  DATA_WIDTH  to RAM BW.
- RAM_CE  out  1  to RAM CE.
- RAM_RDWEN  out  1  to RAM RDWEN (1 write, 0 read).
- RAM_DO  in  DATA_WIDTH  from RAM DO.

## Operation
- Grant combinational from REQ_VALID and registered pointer LAST (index of last granted requester). Search order LAST+1, LAST+2, … wrapping modulo NUM_REQ; first valid wins.
- Granted requester g: REQ_READY[g]=1, RAM_CE=1, RAM_A/DI/BW/RDWEN = slice g. No valid request: REQ_READY=0, RAM_CE=0, RAM_A/DI/BW driven 0.
- On grant, LAST <= g; unchanged when idle.
- Read grant sets PEND_V<=1, PEND_ID<=g; otherwise PEND_V<=0. RSP_VALID = onehot(PEND_ID) & {NUM_REQ{PEND_V}}; RSP_DATA = RAM_DO (passthrough, RAM output is registered).
- Write grant: no response.
- Requesters hold REQ_* stable while VALID && !READY; arbiter makes no assumption beyond sampling on READY.
- No response back-pressure: requester must accept RSP_VALID in its strobe cycle.

## Timing
- Reset (RST_N low, async): LAST=NUM_REQ-1 (requester 0 wins first), PEND_V=0. While RST_N low, REQ_READY=0, RAM_CE=0, RSP_VALID=0 regardless of REQ_VALID (grant gated by reset).
- Request accept: same cycle as REQ_VALID when granted (0-cycle arbitration latency).
- Read latency: grant in cycle t -> RSP_VALID and RSP_DATA in t+1.
- Throughput: one access per cycle total; back-to-back reads give back-to-back responses.
- Write at t then read of same address at t+1 returns new data at t+2 (RAM write completes at end of t).
- Simultaneous requests: exactly one granted; fairness: a continuously valid requester waits at most NUM_REQ-1 cycles.
- Reset mid-read: pending response dropped, no RSP_VALID after release; first post-reset grant goes to lowest valid index ≥0.
- Sole requester: granted every cycle it is valid.

## Structure
- Shared package/header `sp_ram_pkg`: RDWEN_WRITE=1, RDWEN_READ=0 constants; clog2 helper for PEND_ID/LAST width.
- Sub-module `rr_arbiter` (NUM_REQ): combinational rotate-priority grant plus LAST register, async active-low reset; reusable elsewhere. Top holds datapath mux, PEND_V/PEND_ID, response decode.

## Test plan
- Reset/idle: RST_N low with all REQ_VALID=1 -> REQ_READY=0, RAM_CE=0, RSP_VALID=0; release -> first grant to requester 0.
- Single requester: req1 write addr 3 data 0xA5 BW 0xFF, then read addr 3 -> RSP_VALID[1] two cycles after write grant, RSP_DATA=0xA5.
- Bit mask: mem[5]=0xFF, write 0x00 with BW 0x0F, read -> 0xF0.
- Contention: NUM_REQ=3, all reading continuously for 9 cycles -> grant order 0,1,2,0,1,2,0,1,2; each RSP_VALID one cycle after its grant with matching data.
- Held request: req0 and req1 valid; req1 stalls one cycle then granted; REQ_ADDR sampled only on grant cycle.
- Reset mid-read: assert RST_N low in cycle after read grant -> no RSP_VALID; after release, LAST restarts, grant to requester 0.
